// File: rtl/tnoc_flit_if_slicer.sv
// Per-VC flit link slice: STAGES skid stages per channel (1 cycle each, ready registered, full rate)
// plus matching vc_available delay, saturating flit/packet counters and a sticky valid/ready checker.
module tnoc_flit_if_slicer #(
   parameter int CHANNELS      = 2,
   parameter int FLIT_WIDTH    = 64,
   parameter int TAIL_BIT      = 0,
   parameter int STAGES        = 1,
   parameter int COUNTER_WIDTH = 16,
   parameter int CHECK_EN      = 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              i_clear,
   input  logic [CHANNELS-1:0]               in_valid,
   output logic [CHANNELS-1:0]               in_ready,
   input  logic [CHANNELS*FLIT_WIDTH-1:0]    in_flit,
   output logic [CHANNELS-1:0]               in_vc_available,
   output logic [CHANNELS-1:0]               out_valid,
   input  logic [CHANNELS-1:0]               out_ready,
   output logic [CHANNELS*FLIT_WIDTH-1:0]    out_flit,
   input  logic [CHANNELS-1:0]               out_vc_available,
   output logic [CHANNELS*COUNTER_WIDTH-1:0] flit_count,
   output logic [CHANNELS*COUNTER_WIDTH-1:0] packet_count,
   output logic [CHANNELS-1:0]               protocol_error
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} stage_state_t;

   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

   genvar c, s;
   generate
      for (c = 0; c < CHANNELS; c++) begin : g_ch
         // Index 0 is the upstream side, index STAGES the downstream side.
         logic [STAGES:0]       vld;
         logic [STAGES:0]       rdy;
         logic [FLIT_WIDTH-1:0] dat [STAGES+1];

         assign vld[0]      = in_valid[c];
         assign dat[0]      = in_flit[c*FLIT_WIDTH +: FLIT_WIDTH];
         assign rdy[STAGES] = out_ready[c];
         assign in_ready[c] = rdy[0];
         assign out_valid[c] = vld[STAGES];
         assign out_flit[c*FLIT_WIDTH +: FLIT_WIDTH] = dat[STAGES];

         for (s = 0; s < STAGES; s++) begin : g_stage
            stage_state_t          state;
            logic                  rdy_q;
            logic                  vld_q;
            logic [FLIT_WIDTH-1:0] e0;
            logic [FLIT_WIDTH-1:0] e1;
            logic                  push;
            logic                  pop;

            assign push = vld[s] && rdy_q;
            assign pop  = vld_q && rdy[s+1];

            // e0 is always the oldest entry; e1 only holds the skid flit.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  state <= EMPTY;
                  rdy_q <= 1'b1;
                  vld_q <= 1'b0;
                  e0    <= '0;
                  e1    <= '0;
               end else begin
                  case (state)
                     EMPTY: if (push) begin
                        e0    <= dat[s];
                        state <= ONE;
                        vld_q <= 1'b1;
                     end
                     ONE: begin
                        if (push && pop) begin
                           e0 <= dat[s];
                        end else if (push) begin
                           e1    <= dat[s];
                           state <= TWO;
                           rdy_q <= 1'b0;
                        end else if (pop) begin
                           state <= EMPTY;
                           vld_q <= 1'b0;
                        end
                     end
                     TWO: if (pop) begin
                        e0    <= e1;
                        state <= ONE;
                        rdy_q <= 1'b1;
                     end
                     default: begin
                        state <= EMPTY;
                        rdy_q <= 1'b1;
                        vld_q <= 1'b0;
                     end
                  endcase
               end
            end

            assign rdy[s]   = rdy_q;
            assign vld[s+1] = vld_q;
            assign dat[s+1] = e0;
         end

         logic                     fire;
         logic [COUNTER_WIDTH-1:0] fcnt;
         logic [COUNTER_WIDTH-1:0] pcnt;

         assign fire = vld[STAGES] && rdy[STAGES];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               fcnt <= '0;
               pcnt <= '0;
            end else if (i_clear) begin
               fcnt <= '0;
               pcnt <= '0;
            end else if (fire) begin
               if (fcnt != '1) fcnt <= fcnt + CNT_ONE;
               if (dat[STAGES][TAIL_BIT] && pcnt != '1) pcnt <= pcnt + CNT_ONE;
            end
         end

         assign flit_count[c*COUNTER_WIDTH +: COUNTER_WIDTH]   = fcnt;
         assign packet_count[c*COUNTER_WIDTH +: COUNTER_WIDTH] = pcnt;

         if (CHECK_EN != 0) begin : g_chk
            logic                  stall_q;
            logic                  err_q;
            logic [FLIT_WIDTH-1:0] flit_q;

            // A stalled offer must be repeated unchanged on the following cycle.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  stall_q <= 1'b0;
                  err_q   <= 1'b0;
                  flit_q  <= '0;
               end else begin
                  stall_q <= vld[0] && !rdy[0];
                  flit_q  <= dat[0];
                  if (i_clear)
                     err_q <= 1'b0;
                  else if (stall_q && (!vld[0] || dat[0] != flit_q))
                     err_q <= 1'b1;
               end
            end

            assign protocol_error[c] = err_q;
         end else begin : g_nochk
            assign protocol_error[c] = 1'b0;
         end
      end

      if (STAGES == 0) begin : g_vc_pass
         assign in_vc_available = out_vc_available;
      end else begin : g_vc_pipe
         logic [CHANNELS-1:0] vc_pipe [STAGES];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < STAGES; i++) vc_pipe[i] <= '0;
            end else begin
               vc_pipe[0] <= out_vc_available;
               for (int i = 1; i < STAGES; i++) vc_pipe[i] <= vc_pipe[i-1];
            end
         end

         assign in_vc_available = vc_pipe[STAGES-1];
      end
   endgenerate

endmodule

// File: tb/tb_tnoc_flit_if_slicer.sv
// Directed bench for a 2-channel, 2-stage, 16-bit flit, 4-bit counter slicer.
module tb_tnoc_flit_if_slicer;

   localparam int CH = 2;
   localparam int FW = 16;
   localparam int ST = 2;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_clear;
   logic [CH-1:0]     in_valid;
   logic [CH-1:0]     in_ready;
   logic [CH*FW-1:0]  in_flit;
   logic [CH-1:0]     in_vc_available;
   logic [CH-1:0]     out_valid;
   logic [CH-1:0]     out_ready;
   logic [CH*FW-1:0]  out_flit;
   logic [CH-1:0]     out_vc_available;
   logic [CH*CW-1:0]  flit_count;
   logic [CH*CW-1:0]  packet_count;
   logic [CH-1:0]     protocol_error;

   int checks = 0;
   int errors = 0;

   tnoc_flit_if_slicer #(
      .CHANNELS(CH), .FLIT_WIDTH(FW), .TAIL_BIT(0),
      .STAGES(ST), .COUNTER_WIDTH(CW), .CHECK_EN(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_clear(i_clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
      .in_vc_available(in_vc_available),
      .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
      .out_vc_available(out_vc_available),
      .flit_count(flit_count), .packet_count(packet_count),
      .protocol_error(protocol_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] bp_flit(input int n);
      return 16'(32'h2000 + 2 * n + ((n == 15) ? 1 : 0));
   endfunction

   logic [15:0] pkt [4];
   int          sent, rcv, last_rcv, n;
   logic        fire_in;

   initial begin
      pkt[0] = 16'h1000; pkt[1] = 16'h1002; pkt[2] = 16'h1004; pkt[3] = 16'h1007;
      rst_n = 1'b0; i_clear = 1'b0; in_valid = '0; out_ready = '0;
      in_flit = '0; out_vc_available = '0;
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h3);
      chk("rst_vc", 32'(in_vc_available), 32'h0);
      chk("rst_flit_count", 32'(flit_count), 32'h0);
      chk("rst_packet_count", 32'(packet_count), 32'h0);
      chk("rst_error", 32'(protocol_error), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // 4-flit packet on ch0, two cycles through two stages.
      out_ready = 2'b11;
      for (int k = 0; k < 6; k++) begin
         in_valid[0] = (k < 4);
         if (k < 4) in_flit[15:0] = pkt[k];
         step();
         chk("lat_valid0", 32'(out_valid[0]), 32'((k >= 1 && k <= 4) ? 1 : 0));
         if (k >= 1 && k <= 4) chk("lat_flit0", 32'(out_flit[15:0]), 32'(pkt[k-1]));
         chk("lat_valid1", 32'(out_valid[1]), 32'h0);
      end
      chk("pkt_flit_count0", 32'(flit_count[3:0]), 32'd4);
      chk("pkt_packet_count0", 32'(packet_count[3:0]), 32'd1);
      chk("pkt_flit_count1", 32'(flit_count[7:4]), 32'd0);
      chk("pkt_packet_count1", 32'(packet_count[7:4]), 32'd0);

      i_clear = 1'b1; step(); i_clear = 1'b0;
      chk("clear_counts", 32'(flit_count), 32'h0);

      // 16-flit stream on ch0 with out_ready low for cycles 5..8.
      sent = 0; rcv = 0; last_rcv = -1;
      for (int c = 0; c < 26; c++) begin
         in_valid[0]  = (sent < 16);
         in_flit[15:0] = bp_flit(sent);
         out_ready[0] = !(c >= 5 && c <= 8);
         chk("bp_in_ready", 32'(in_ready[0]), 32'((c >= 7 && c <= 10) ? 0 : 1));
         if (out_valid[0] && out_ready[0]) begin
            chk("bp_order", 32'(out_flit[15:0]), 32'(bp_flit(rcv)));
            rcv++;
            last_rcv = c;
         end
         fire_in = in_valid[0] && in_ready[0];
         step();
         if (fire_in) sent++;
      end
      in_valid[0] = 1'b0;
      out_ready = 2'b11;
      chk("bp_received", 32'(rcv), 32'd16);
      chk("bp_last_cycle", 32'(last_rcv), 32'd21);
      chk("bp_flit_sat", 32'(flit_count[3:0]), 32'd15);
      chk("bp_packets", 32'(packet_count[3:0]), 32'd1);

      // 20 single-flit packets on ch1 saturate both counters.
      i_clear = 1'b1; step(); i_clear = 1'b0;
      sent = 0;
      for (int c = 0; c < 26; c++) begin
         in_valid[1] = (sent < 20);
         in_flit[31:16] = 16'(32'h3001 + 2 * sent);
         fire_in = in_valid[1] && in_ready[1];
         step();
         if (fire_in) sent++;
      end
      in_valid[1] = 1'b0;
      chk("sat_flit1", 32'(flit_count[7:4]), 32'd15);
      chk("sat_packet1", 32'(packet_count[7:4]), 32'd15);
      chk("sat_flit0", 32'(flit_count[3:0]), 32'd0);

      // Clear wins over a transfer in the same cycle.
      in_valid[1] = 1'b1; in_flit[31:16] = 16'h3fff;
      step();
      in_valid[1] = 1'b0;
      step();
      chk("clr_xfer_valid", 32'(out_valid[1]), 32'd1);
      i_clear = 1'b1; step(); i_clear = 1'b0;
      chk("clr_xfer_gone", 32'(out_valid[1]), 32'd0);
      chk("clr_xfer_flit", 32'(flit_count), 32'h0);
      chk("clr_xfer_packet", 32'(packet_count), 32'h0);

      // vc_available delayed by two cycles.
      out_vc_available = 2'b10;
      chk("vc_t0", 32'(in_vc_available), 32'h0);
      step();
      chk("vc_t1", 32'(in_vc_available), 32'h0);
      step();
      chk("vc_t2", 32'(in_vc_available), 32'h2);
      out_vc_available = 2'b00;
      step();
      chk("vc_fall1", 32'(in_vc_available), 32'h2);
      step();
      chk("vc_fall2", 32'(in_vc_available), 32'h0);

      // Fill ch0, then violate the handshake while stalled.
      out_ready = 2'b10;
      in_valid[0] = 1'b1; n = 0;
      for (int c = 0; c < 10 && in_ready[0]; c++) begin
         in_flit[15:0] = 16'(32'h4000 + n);
         step();
         n++;
      end
      chk("fill_count", 32'(n), 32'd4);
      chk("fill_in_ready", 32'(in_ready[0]), 32'd0);
      in_flit[15:0] = 16'h4004;
      step();
      step();
      chk("legal_stall_err", 32'(protocol_error), 32'h0);
      in_valid[0] = 1'b0;
      step();
      chk("violation_err", 32'(protocol_error), 32'h1);
      step();
      step();
      chk("sticky_err", 32'(protocol_error), 32'h1);
      i_clear = 1'b1; step(); i_clear = 1'b0;
      chk("clear_err", 32'(protocol_error), 32'h0);

      // Asynchronous reset with flits buffered.
      chk("pre_rst_valid", 32'(out_valid[0]), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'h0);
      chk("async_rst_ready", 32'(in_ready), 32'h3);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 2'b11;
      step();
      step();
      chk("post_rst_valid", 32'(out_valid), 32'h0);
      chk("post_rst_ready", 32'(in_ready), 32'h3);
      chk("post_rst_flits", 32'(flit_count), 32'h0);
      chk("post_rst_packets", 32'(packet_count), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
